id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the five-stage miniRV pipeline, sitting directly upstream of the ALU. Each cycle it latches the decoded instruction from ID, resolves RAW hazards by forwarding from EX/MEM/WB into the operand values it captures, detects load-use hazards (stalls IF/ID and inserts a bubble), and kills the ID instruction on a taken branch/jump flush. Its registered outputs drive the ALU operand, immediate and control inputs directly.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the load-use bubble counter
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rfrd1, id_rfrd2  in  XLEN  register-file read data
- id_sext  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rf_we, id_is_load, id_dram_we, id_alub_sel  in  1  decoded controls
- id_wd_sel  in  2  write-back source select
- id_alu_op  in  4  ALU opcode
- id_br_type  in  3  branch/jump type, 0 = none
- ex_rf_we, ex_is_load  in  1  current EX instruction controls (fed back from this block's own outputs)
- ex_wd  in  XLEN  EX result (ALU C)
- mem_rf_we, wb_rf_we  in  1  MEM/WB write enables
- mem_rd, wb_rd  in  5  MEM/WB destinations
- mem_wd, wb_wd  in  XLEN  MEM/WB write-back data
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- stall_ifid  out  1  combinational; hold PC and IF/ID register
- ex_valid, ex_rf_we, ex_is_load, ex_dram_we, alub_sel  out  1  registered
- ex_pc, rfrd1, rfrd2, sextext  out  XLEN  registered
- ex_rd  out  5; alu_op  out  4; ex_wd_sel  out  2; ex_br_type  out  3  registered
- bubble_cnt  out  CNT_W  registered count of load-use bubbles inserted

## Operation
- Forwarding (combinational, applied to id_rfrd1/id_rfrd2 before latch), per operand with index rs:
  - rs == 0: no forwarding, value is id_rfrdN (x0 reads 0 from RF).
  - Priority EX > MEM > WB: source matches if its rf_we=1 and rd==rs; EX source additionally requires ex_valid=1 and ex_is_load=0.
  - No match: id_rfrdN.
- Load-use hazard: luh = id_valid & ex_valid & ex_is_load & ex_rf_we & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_ifid = luh & ~flush.
- Next-state selection on each rising edge, priority order:
  1. rst: all outputs 0 (ex_valid=0, all enables 0, alu_op=0, data 0); bubble_cnt=0.
  2. flush: bubble (ex_valid=0, ex_rf_we=ex_dram_we=ex_is_load=0, ex_br_type=0, other fields 0). bubble_cnt unchanged.
  3. luh: same bubble; bubble_cnt += 1, saturating at 2^CNT_W-1.
  4. else: latch ID fields with forwarded operands; if id_valid=0 latch as bubble.
- Bubble guarantees no architectural side effect downstream regardless of ALU output.

## Timing
- Latency 1 cycle ID->EX; operands seen by ALU in cycle N+1 reflect forwarding state at cycle N.
- Load-use costs exactly one bubble: cycle N stall_ifid=1; cycle N+1 load is in MEM, ID instruction re-presented and forwarded from mem_wd.
- flush and luh in same cycle: flush wins, stall_ifid=0, one bubble, counter not incremented.
- rst asserted mid-stall: next cycle all outputs 0, stall_ifid follows combinationally from (now invalid) EX, i.e. 0.
- Counter saturates; never wraps.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 -> all outputs 0, bubble_cnt=0, stall_ifid=0.
- EX forward: EX rd=5 non-load ex_wd=0x1234, ID rs1=5 id_rfrd1=0 -> next cycle rfrd1=0x1234; same with MEM rd=5 mem_wd=0x9 also matching -> still 0x1234.
- x0 guard: WB rd=0 wb_rf_we=1 wb_wd=0xFFFF, ID rs2=0 id_rfrd2=0 -> rfrd2=0.
- Load-use: EX lw rd=7, ID add rs2=7 -> stall_ifid=1, next cycle ex_valid=0, bubble_cnt=1; following cycle mem_rd=7 mem_wd=0xAB -> rfrd2=0xAB, ex_valid=1.
- Flush vs load-use same cycle -> stall_ifid=0, ex_valid=0, bubble_cnt unchanged.
- Saturation: CNT_W=2, four consecutive load-use events -> bubble_cnt stays 3.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the miniRV five-stage pipeline: captures the decoded
// instruction with forwarded operands, and inserts bubbles on load-use hazards and flushes.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rfrd1,
  input  logic [XLEN-1:0]  id_rfrd2,
  input  logic [XLEN-1:0]  id_sext,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             id_dram_we,
  input  logic             id_alub_sel,
  input  logic [1:0]       id_wd_sel,
  input  logic [3:0]       id_alu_op,
  input  logic [2:0]       id_br_type,
  input  logic [XLEN-1:0]  ex_wd,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_wd,
  input  logic             wb_rf_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wd,
  input  logic             flush,
  output logic             stall_ifid,
  output logic             ex_valid,
  output logic             ex_rf_we,
  output logic             ex_is_load,
  output logic             ex_dram_we,
  output logic             alub_sel,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  rfrd1,
  output logic [XLEN-1:0]  rfrd2,
  output logic [XLEN-1:0]  sextext,
  output logic [4:0]       ex_rd,
  output logic [3:0]       alu_op,
  output logic [1:0]       ex_wd_sel,
  output logic [2:0]       ex_br_type,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             ex_valid_q,   ex_valid_d;
  logic             ex_rf_we_q,   ex_rf_we_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic             ex_dram_we_q, ex_dram_we_d;
  logic             alub_sel_q,   alub_sel_d;
  logic [XLEN-1:0]  ex_pc_q,      ex_pc_d;
  logic [XLEN-1:0]  rfrd1_q,      rfrd1_d;
  logic [XLEN-1:0]  rfrd2_q,      rfrd2_d;
  logic [XLEN-1:0]  sextext_q,    sextext_d;
  logic [4:0]       ex_rd_q,      ex_rd_d;
  logic [3:0]       alu_op_q,     alu_op_d;
  logic [1:0]       ex_wd_sel_q,  ex_wd_sel_d;
  logic [2:0]       ex_br_type_q, ex_br_type_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic             ex_fwd_en;
  logic             luh;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  // The EX-stage state used for forwarding and hazard checks is this block's own
  // registered output, so it is read from the flops rather than from extra ports.
  assign ex_fwd_en = ex_valid_q & ex_rf_we_q & ~ex_is_load_q;

  always_comb begin
    fwd_rs1 = id_rfrd1;
    if (id_rs1 != 5'd0) begin
      if (ex_fwd_en && (ex_rd_q == id_rs1)) begin
        fwd_rs1 = ex_wd;
      end else if (mem_rf_we && (mem_rd == id_rs1)) begin
        fwd_rs1 = mem_wd;
      end else if (wb_rf_we && (wb_rd == id_rs1)) begin
        fwd_rs1 = wb_wd;
      end
    end
  end

  always_comb begin
    fwd_rs2 = id_rfrd2;
    if (id_rs2 != 5'd0) begin
      if (ex_fwd_en && (ex_rd_q == id_rs2)) begin
        fwd_rs2 = ex_wd;
      end else if (mem_rf_we && (mem_rd == id_rs2)) begin
        fwd_rs2 = mem_wd;
      end else if (wb_rf_we && (wb_rd == id_rs2)) begin
        fwd_rs2 = wb_wd;
      end
    end
  end

  // A load in EX cannot forward its data yet, so a dependent ID instruction waits one cycle.
  assign luh = id_valid & ex_valid_q & ex_is_load_q & ex_rf_we_q & (ex_rd_q != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));

  assign stall_ifid = luh & ~flush;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (stall_ifid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Flush, load-use and an empty ID slot all collapse to an all-zero bubble.
  always_comb begin
    ex_valid_d   = 1'b0;
    ex_rf_we_d   = 1'b0;
    ex_is_load_d = 1'b0;
    ex_dram_we_d = 1'b0;
    alub_sel_d   = 1'b0;
    ex_pc_d      = '0;
    rfrd1_d      = '0;
    rfrd2_d      = '0;
    sextext_d    = '0;
    ex_rd_d      = 5'd0;
    alu_op_d     = 4'd0;
    ex_wd_sel_d  = 2'd0;
    ex_br_type_d = 3'd0;
    if (!flush && !luh && id_valid) begin
      ex_valid_d   = 1'b1;
      ex_rf_we_d   = id_rf_we;
      ex_is_load_d = id_is_load;
      ex_dram_we_d = id_dram_we;
      alub_sel_d   = id_alub_sel;
      ex_pc_d      = id_pc;
      rfrd1_d      = fwd_rs1;
      rfrd2_d      = fwd_rs2;
      sextext_d    = id_sext;
      ex_rd_d      = id_rd;
      alu_op_d     = id_alu_op;
      ex_wd_sel_d  = id_wd_sel;
      ex_br_type_d = id_br_type;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_rf_we_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_dram_we_q <= 1'b0;
      alub_sel_q   <= 1'b0;
      ex_pc_q      <= '0;
      rfrd1_q      <= '0;
      rfrd2_q      <= '0;
      sextext_q    <= '0;
      ex_rd_q      <= 5'd0;
      alu_op_q     <= 4'd0;
      ex_wd_sel_q  <= 2'd0;
      ex_br_type_q <= 3'd0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rf_we_q   <= ex_rf_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_dram_we_q <= ex_dram_we_d;
      alub_sel_q   <= alub_sel_d;
      ex_pc_q      <= ex_pc_d;
      rfrd1_q      <= rfrd1_d;
      rfrd2_q      <= rfrd2_d;
      sextext_q    <= sextext_d;
      ex_rd_q      <= ex_rd_d;
      alu_op_q     <= alu_op_d;
      ex_wd_sel_q  <= ex_wd_sel_d;
      ex_br_type_q <= ex_br_type_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rf_we   = ex_rf_we_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_dram_we = ex_dram_we_q;
  assign alub_sel   = alub_sel_q;
  assign ex_pc      = ex_pc_q;
  assign rfrd1      = rfrd1_q;
  assign rfrd2      = rfrd2_q;
  assign sextext    = sextext_q;
  assign ex_rd      = ex_rd_q;
  assign alu_op     = alu_op_q;
  assign ex_wd_sel  = ex_wd_sel_q;
  assign ex_br_type = ex_br_type_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed vector table, hand-written corner sequences and
// randomized traffic compared against a pipeline-slot reference model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rfrd1;
    logic [31:0] id_rfrd2;
    logic [31:0] id_sext;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_rf_we;
    logic        id_is_load;
    logic        id_dram_we;
    logic        id_alub_sel;
    logic [1:0]  id_wd_sel;
    logic [3:0]  id_alu_op;
    logic [2:0]  id_br_type;
    logic [31:0] ex_wd;
    logic        mem_rf_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wd;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic        is_load;
    logic        dram_we;
    logic        alub_sel;
    logic [31:0] pc;
    logic [31:0] rfrd1;
    logic [31:0] rfrd2;
    logic [31:0] sext;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  wd_sel;
    logic [2:0]  br_type;
  } slot_t;

  typedef struct {
    in_t         in;
    logic        exp_stall;
    logic        exp_valid;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;
  int  checks = 0;
  int  failures = 0;

  logic        o_stall, o_valid, o_rf_we, o_is_load, o_dram_we, o_alub_sel;
  logic [31:0] o_pc, o_r1, o_r2, o_sext;
  logic [4:0]  o_rd;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_wd_sel;
  logic [2:0]  o_br_type;
  logic [15:0] o_cnt;

  logic        s_stall, s_valid, s_rf_we, s_is_load, s_dram_we, s_alub_sel;
  logic [31:0] s_pc, s_r1, s_r2, s_sext;
  logic [4:0]  s_rd;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_wd_sel;
  logic [2:0]  s_br_type;
  logic [1:0]  s_cnt;

  id_ex_reg dut (
    .clk(clk), .rst(cur.rst), .id_valid(cur.id_valid), .id_pc(cur.id_pc),
    .id_rfrd1(cur.id_rfrd1), .id_rfrd2(cur.id_rfrd2), .id_sext(cur.id_sext),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2), .id_rd(cur.id_rd),
    .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2), .id_rf_we(cur.id_rf_we),
    .id_is_load(cur.id_is_load), .id_dram_we(cur.id_dram_we), .id_alub_sel(cur.id_alub_sel),
    .id_wd_sel(cur.id_wd_sel), .id_alu_op(cur.id_alu_op), .id_br_type(cur.id_br_type),
    .ex_wd(cur.ex_wd), .mem_rf_we(cur.mem_rf_we), .mem_rd(cur.mem_rd), .mem_wd(cur.mem_wd),
    .wb_rf_we(cur.wb_rf_we), .wb_rd(cur.wb_rd), .wb_wd(cur.wb_wd), .flush(cur.flush),
    .stall_ifid(o_stall), .ex_valid(o_valid), .ex_rf_we(o_rf_we), .ex_is_load(o_is_load),
    .ex_dram_we(o_dram_we), .alub_sel(o_alub_sel), .ex_pc(o_pc), .rfrd1(o_r1), .rfrd2(o_r2),
    .sextext(o_sext), .ex_rd(o_rd), .alu_op(o_alu_op), .ex_wd_sel(o_wd_sel),
    .ex_br_type(o_br_type), .bubble_cnt(o_cnt)
  );

  id_ex_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(cur.rst), .id_valid(cur.id_valid), .id_pc(cur.id_pc),
    .id_rfrd1(cur.id_rfrd1), .id_rfrd2(cur.id_rfrd2), .id_sext(cur.id_sext),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2), .id_rd(cur.id_rd),
    .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2), .id_rf_we(cur.id_rf_we),
    .id_is_load(cur.id_is_load), .id_dram_we(cur.id_dram_we), .id_alub_sel(cur.id_alub_sel),
    .id_wd_sel(cur.id_wd_sel), .id_alu_op(cur.id_alu_op), .id_br_type(cur.id_br_type),
    .ex_wd(cur.ex_wd), .mem_rf_we(cur.mem_rf_we), .mem_rd(cur.mem_rd), .mem_wd(cur.mem_wd),
    .wb_rf_we(cur.wb_rf_we), .wb_rd(cur.wb_rd), .wb_wd(cur.wb_wd), .flush(cur.flush),
    .stall_ifid(s_stall), .ex_valid(s_valid), .ex_rf_we(s_rf_we), .ex_is_load(s_is_load),
    .ex_dram_we(s_dram_we), .alub_sel(s_alub_sel), .ex_pc(s_pc), .rfrd1(s_r1), .rfrd2(s_r2),
    .sextext(s_sext), .ex_rd(s_rd), .alu_op(s_alu_op), .ex_wd_sel(s_wd_sel),
    .ex_br_type(s_br_type), .bubble_cnt(s_cnt)
  );

  slot_t dut_slot;
  assign dut_slot = {o_valid, o_rf_we, o_is_load, o_dram_we, o_alub_sel, o_pc, o_r1, o_r2,
                     o_sext, o_rd, o_alu_op, o_wd_sel, o_br_type};

  // Reference model: the instruction currently sitting in EX plus a plain bubble tally.
  slot_t mslot = '0;
  int    mcnt = 0;

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf,
                                            input slot_t ex, input in_t v);
    if (rs == 5'd0) return rf;
    if (ex.valid && ex.rf_we && !ex.is_load && ex.rd == rs) return v.ex_wd;
    if (v.mem_rf_we && v.mem_rd == rs) return v.mem_wd;
    if (v.wb_rf_we && v.wb_rd == rs) return v.wb_wd;
    return rf;
  endfunction

  function automatic logic model_luh(input in_t v, input slot_t ex);
    logic reads_load;
    reads_load = (v.id_use_rs1 && v.id_rs1 == ex.rd) || (v.id_use_rs2 && v.id_rs2 == ex.rd);
    return v.id_valid && ex.valid && ex.is_load && ex.rf_we && ex.rd != 5'd0 && reads_load;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input in_t v);
    cur = v;
  endtask

  // Computes the model's next state from the inputs now applied, then crosses one rising edge.
  task automatic advance();
    slot_t nx;
    int    nc;
    nx = mslot;
    nc = mcnt;
    if (cur.rst) begin
      nx = '0;
      nc = 0;
    end else if (cur.flush || !cur.id_valid) begin
      nx = '0;
    end else if (model_luh(cur, mslot)) begin
      nx = '0;
      nc = nc + 1;
    end else begin
      nx.valid    = 1'b1;
      nx.rf_we    = cur.id_rf_we;
      nx.is_load  = cur.id_is_load;
      nx.dram_we  = cur.id_dram_we;
      nx.alub_sel = cur.id_alub_sel;
      nx.pc       = cur.id_pc;
      nx.rfrd1    = model_fwd(cur.id_rs1, cur.id_rfrd1, mslot, cur);
      nx.rfrd2    = model_fwd(cur.id_rs2, cur.id_rfrd2, mslot, cur);
      nx.sext     = cur.id_sext;
      nx.rd       = cur.id_rd;
      nx.alu_op   = cur.id_alu_op;
      nx.wd_sel   = cur.id_wd_sel;
      nx.br_type  = cur.id_br_type;
    end
    @(posedge clk);
    mslot = nx;
    mcnt  = nc;
    @(negedge clk);
  endtask

  function automatic in_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2,
                             input logic we, input logic ld, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] exwd,
                             input logic mwe, input logic [4:0] mrd, input logic [31:0] mwd,
                             input logic wwe, input logic [4:0] wrd, input logic [31:0] wwd,
                             input logic fl);
    in_t v;
    v = '0;
    v.id_valid = vld;  v.id_rs1 = rs1;  v.id_rs2 = rs2;  v.id_rd = rd;
    v.id_use_rs1 = u1; v.id_use_rs2 = u2; v.id_rf_we = we; v.id_is_load = ld;
    v.id_rfrd1 = r1;   v.id_rfrd2 = r2;   v.ex_wd = exwd;
    v.mem_rf_we = mwe; v.mem_rd = mrd;    v.mem_wd = mwd;
    v.wb_rf_we = wwe;  v.wb_rd = wrd;     v.wb_wd = wwd;
    v.flush = fl;
    v.id_pc = 32'h1000 + {25'd0, rd, 2'b00};
    v.id_sext = 32'hFFFF_FF00 | {27'd0, rd};
    v.id_alu_op = rd[3:0];
    v.id_wd_sel = rd[1:0];
    v.id_alub_sel = rd[0];
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rst         = ($urandom_range(0, 49) == 0);
    v.id_valid    = ($urandom_range(0, 7) != 0);
    v.id_pc       = $urandom;
    v.id_rfrd1    = $urandom;
    v.id_rfrd2    = $urandom;
    v.id_sext     = $urandom;
    v.id_rs1      = 5'($urandom_range(0, 7));
    v.id_rs2      = 5'($urandom_range(0, 7));
    v.id_rd       = 5'($urandom_range(0, 7));
    v.id_use_rs1  = 1'($urandom);
    v.id_use_rs2  = 1'($urandom);
    v.id_rf_we    = ($urandom_range(0, 3) != 0);
    v.id_is_load  = ($urandom_range(0, 2) == 0);
    v.id_dram_we  = 1'($urandom);
    v.id_alub_sel = 1'($urandom);
    v.id_wd_sel   = 2'($urandom);
    v.id_alu_op   = 4'($urandom);
    v.id_br_type  = 3'($urandom);
    v.ex_wd       = $urandom;
    v.mem_rf_we   = 1'($urandom);
    v.mem_rd      = 5'($urandom_range(0, 7));
    v.mem_wd      = $urandom;
    v.wb_rf_we    = 1'($urandom);
    v.wb_rd       = 5'($urandom_range(0, 7));
    v.wb_wd       = $urandom;
    v.flush       = ($urandom_range(0, 7) == 0);
    return v;
  endfunction

  vec_t tbl[13];
  in_t  v;

  initial begin
    // Directed cycles after reset; expected values hold after each row's rising edge.
    tbl[0]  = '{mk(1,1,2,5,1,1,1,0,32'h11,32'h22,0,0,0,0,0,0,0,0), 0,1,32'h11,32'h22,0};
    tbl[1]  = '{mk(1,5,6,8,1,1,1,0,0,32'h66,32'h1234,0,0,0,0,0,0,0), 0,1,32'h1234,32'h66,0};
    tbl[2]  = '{mk(1,8,0,7,1,1,1,1,0,0,32'h1234,1,8,32'h9,1,0,32'hFFFF,0), 0,1,32'h1234,0,0};
    tbl[3]  = '{mk(1,1,7,9,1,1,1,0,32'h1,0,32'hDEAD,0,0,0,0,0,0,0), 1,0,0,0,1};
    tbl[4]  = '{mk(1,1,7,9,1,1,1,0,32'h1,0,32'hDEAD,1,7,32'hAB,0,0,0,0), 0,1,32'h1,32'hAB,1};
    tbl[5]  = '{mk(1,3,4,10,1,1,1,1,0,32'h40,32'h5,1,3,32'h33,1,3,32'h44,0), 0,1,32'h33,32'h40,1};
    tbl[6]  = '{mk(1,10,0,11,1,0,1,0,0,0,0,0,0,0,0,0,0,1), 0,0,0,0,1};
    tbl[7]  = '{mk(0,1,2,11,1,1,1,0,32'h5,32'h6,0,0,0,0,0,0,0,0), 0,0,0,0,1};
    tbl[8]  = '{mk(1,12,13,14,1,1,1,1,0,32'h13,0,0,0,0,1,12,32'h77,0), 0,1,32'h77,32'h13,1};
    tbl[9]  = '{mk(1,14,2,14,0,1,1,1,32'h5,32'h2,32'hBEEF,0,0,0,0,0,0,0), 0,1,32'h5,32'h2,1};
    tbl[10] = '{mk(1,14,2,15,1,1,1,0,32'h5,32'h2,0,0,0,0,0,0,0,0), 1,0,0,0,2};
    tbl[11] = '{mk(1,0,0,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0), 0,1,0,0,2};
    tbl[12] = '{mk(1,0,0,3,1,1,1,0,0,0,32'h99,0,0,0,0,0,0,0), 0,1,0,0,2};

    // Reset held two cycles with a live ID instruction.
    v = mk(1,1,2,5,1,1,1,1,32'h55,32'h66,32'h77,1,1,32'h88,1,2,32'h99,0);
    v.rst = 1'b1;
    applyStimulus(v);
    advance();
    advance();
    checkOutput("reset_slot", 160'(dut_slot), 160'd0);
    checkOutput("reset_cnt", 160'(o_cnt), 160'd0);
    checkOutput("reset_stall", 160'(o_stall), 160'd0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].in);
      #1;
      checkOutput($sformatf("vec%0d_stall", i), 160'(o_stall), 160'(tbl[i].exp_stall));
      advance();
      checkOutput($sformatf("vec%0d_valid", i), 160'(o_valid), 160'(tbl[i].exp_valid));
      checkOutput($sformatf("vec%0d_rfrd1", i), 160'(o_r1), 160'(tbl[i].exp_r1));
      checkOutput($sformatf("vec%0d_rfrd2", i), 160'(o_r2), 160'(tbl[i].exp_r2));
      checkOutput($sformatf("vec%0d_cnt", i), 160'(o_cnt), 160'(tbl[i].exp_cnt));
    end

    // Saturation: four load-use events against the 2-bit counter.
    v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v.rst = 1'b1;
    applyStimulus(v);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(1,1,0,7,1,0,1,1,32'h3,0,0,0,0,0,0,0,0,0));
      advance();
      applyStimulus(mk(1,7,0,7,1,0,1,1,0,0,0,0,0,0,0,0,0,0));
      #1;
      checkOutput($sformatf("sat%0d_stall", i), 160'(s_stall), 160'd1);
      advance();
      checkOutput($sformatf("sat%0d_cnt2", i), 160'(s_cnt), 160'((i + 1 > 3) ? 3 : i + 1));
      checkOutput($sformatf("sat%0d_cnt16", i), 160'(o_cnt), 160'(i + 1));
    end

    // Reset arriving while a load-use stall is being requested.
    applyStimulus(mk(1,1,0,7,1,0,1,1,32'h3,0,0,0,0,0,0,0,0,0));
    advance();
    v = mk(1,7,0,9,1,0,1,0,0,0,0,0,0,0,0,0,0,0);
    v.rst = 1'b1;
    applyStimulus(v);
    #1;
    checkOutput("rststall_pre", 160'(o_stall), 160'd1);
    advance();
    checkOutput("rststall_slot", 160'(dut_slot), 160'd0);
    checkOutput("rststall_cnt", 160'(o_cnt), 160'd0);
    checkOutput("rststall_stall", 160'(o_stall), 160'd0);

    // Randomized traffic against the reference model.
    v = rand_in();
    v.rst = 1'b1;
    applyStimulus(v);
    advance();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(rand_in());
      #1;
      checkOutput($sformatf("rnd%0d_stall", i), 160'(o_stall),
                  160'(model_luh(cur, mslot) && !cur.flush));
      advance();
      checkOutput($sformatf("rnd%0d_slot", i), 160'(dut_slot), 160'(mslot));
      checkOutput($sformatf("rnd%0d_cnt", i), 160'(o_cnt), 160'((mcnt > 65535) ? 65535 : mcnt));
      checkOutput($sformatf("rnd%0d_satcnt", i), 160'(s_cnt), 160'((mcnt > 3) ? 3 : mcnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
